lsu_bus_bridge: RTL
===================

Name: lsu_bus_bridge

Overview:
Load/store bridge between the Execute stage memory outputs and an external data RAM with variable latency and a req/gnt/rvalid handshake. Shifts byte lanes by address, issues one bus transaction at a time and stalls the core until it completes. Returns lane-extracted, optionally sign-extended load data to write-back. Replaces the fixed-latency memory path in the core's memory-access stage.

Parameters:
TIMEOUT_CYC, 16, bus cycles to wait for gnt or rvalid before aborting (counter width is clog2(TIMEOUT_CYC+1))
RD_ZERO_ON_ERR, 1, when 1 an aborted load returns 0 with LSU_rd_vld=1; when 0 no LSU_rd_vld is produced

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
EX_MEMaddr  in  32  byte address from Execute
EX_MEMrden  in  4  load size mask, lane-0 relative: 0001 byte, 0011 half, 1111 word, 0000 none
EX_MEMwren  in  4  store size mask, same encoding as EX_MEMrden
EX_MEMwrdata  in  32  store data, lane-0 relative
EX_ld_signed  in  1  1 = sign-extend the load (LB/LH), 0 = zero-extend (LBU/LHU)
lsu_stall  out  1  hold IF/ID/EX while a transaction is pending
LSU_rd_vld  out  1  one-cycle pulse: load data valid
LSU_rd_data  out  32  extended load result
lsu_err  out  1  one-cycle pulse: timeout, illegal request or misalignment trap
lsu_misalign  out  1  one-cycle pulse: misaligned access trapped (tied 0 without the macro)
bus_req  out  1  request valid; held until bus_gnt
bus_we  out  1  1 = write
bus_addr  out  32  word address, {addr[31:2],2'b00}
bus_be  out  4  byte enables after the lane shift
bus_wdata  out  32  store data shifted by 8*addr[1:0]
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; captured request cleared. Reset mid-transaction aborts it with no lsu_err, and bus_req drops in the next cycle.
- FSM states:
  - IDLE: a request is any nonzero rden or wren. On a request, lsu_stall=1 combinationally in the same cycle and the request is captured: addr, be = mask<<addr[1:0], wdata<<8*addr[1:0], size, ld_signed. Next state is REQ.
  - Illegal request (rden and wren both nonzero, or a mask not in {0001,0011,1111}): no bus access, lsu_err pulses next cycle, state stays IDLE, lsu_stall=0.
  - REQ: bus_req=1 and bus signals stable. On bus_gnt, a write goes to IDLE with lsu_stall=0 in the gnt cycle, and a read goes to RDWAIT. Timeout counter increments each REQ cycle.
  - RDWAIT: bus_req=0. On bus_rvalid, lsu_stall=0 in the same cycle, the result is registered, LSU_rd_vld pulses the next cycle, and state returns to IDLE. If bus_gnt and bus_rvalid both arrive in the REQ cycle, the read completes directly from REQ (zero-wait RAM).
- Timeout: the counter is reset on every state entry. When it reaches TIMEOUT_CYC in REQ or RDWAIT:
  - the transaction is abandoned and lsu_err pulses;
  - if it was a load and RD_ZERO_ON_ERR=1, LSU_rd_vld pulses with 0;
  - state returns to IDLE and lsu_stall drops that cycle.
- Load extraction: r = bus_rdata >> 8*addr[1:0]. For byte loads, bits [31:8] are r[7] when signed, else 0. For half loads, bits [31:16] are r[15] when signed, else 0. For word loads, r is used as-is.
- Stores produce no LSU_rd_vld.
- The core holds its inputs stable while lsu_stall=1. The bridge ignores its inputs outside IDLE.
- Single outstanding transaction. Latency is min 2 cycles for a write (capture, gnt) and min 2 cycles plus the LSU_rd_vld register for a read.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: half at addr[0]=1 or word at addr[1:0]!=0 issues no bus access. lsu_misalign and lsu_err pulse the next cycle, there is no LSU_rd_vld, state stays IDLE, and lsu_stall=0.
- Undefined: low address bits are cleared to natural alignment (half addr[0]=0, word addr[1:0]=0) before the lane shift, the access proceeds normally, and lsu_misalign is tied 0.

Test Plan:
- Store word: addr=0x100, wren=1111, wdata=0xDEADBEEF, gnt after 3 cycles -> bus_addr=0x100, be=1111, wdata=0xDEADBEEF; lsu_stall high 4 cycles; no LSU_rd_vld.
- Signed byte load: addr=0x203, rden=0001, signed=1, rvalid with rdata=0x80112233 two cycles after gnt -> be=1000; LSU_rd_data=0xFFFFFF80, LSU_rd_vld one cycle after rvalid.
- Unsigned half load: addr=0x202, rden=0011, signed=0, rdata=0xBEEF1234 with gnt and rvalid in the same cycle -> LSU_rd_data=0x0000BEEF; store half at 0x202 with wdata=0x0000ABCD -> be=1100, bus_wdata=0xABCD0000.
- Timeout: load at 0x300 with bus_gnt never asserted, TIMEOUT_CYC=16 -> after 16 REQ cycles lsu_err pulses, LSU_rd_vld=1 with 0, lsu_stall drops, and bus_req drops next cycle.
- Illegal request and reset: rden=1111 with wren=0001 -> lsu_err pulse, no bus_req. Separately, rst asserted in RDWAIT -> all outputs 0 next cycle, no LSU_rd_vld.
- Misalign: word load at addr=0x102 with LSU_MISALIGN_TRAP_EN defined -> lsu_misalign=lsu_err=1 for one cycle, no bus_req. Same stimulus with the macro undefined -> bus_addr=0x100, be=1111.

Source files
------------

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge from the Execute stage to a req/gnt/rvalid data RAM, one transaction at a time.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module lsu_bus_bridge #(
    parameter int unsigned TIMEOUT_CYC    = 16,
    parameter bit          RD_ZERO_ON_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEMaddr,
    input  logic [3:0]  EX_MEMrden,
    input  logic [3:0]  EX_MEMwren,
    input  logic [31:0] EX_MEMwrdata,
    input  logic        EX_ld_signed,
    output logic        lsu_stall,
    output logic        LSU_rd_vld,
    output logic [31:0] LSU_rd_data,
    output logic        lsu_err,
    output logic        lsu_misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StReq, StRdWait} state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic [1:0]      off_q;
    logic [3:0]      size_q;
    logic            sgn_q;
    logic            mis_q;

    logic [3:0]  mask;
    logic        req_any;
    logic        illegal;
    logic        trap;
    logic        start;
    logic        tmo;
    logic        rd_done;
    logic        abort;
    logic [1:0]  off;
    logic [31:0] shifted;
    logic [31:0] ld_ext;

    assign mask    = EX_MEMrden | EX_MEMwren;
    assign req_any = |mask;
    assign illegal = req_any && (((|EX_MEMrden) && (|EX_MEMwren)) ||
                     !(mask == 4'b0001 || mask == 4'b0011 || mask == 4'b1111));
`ifdef LSU_MISALIGN_TRAP_EN
    assign off  = EX_MEMaddr[1:0];
    assign trap = req_any && !illegal &&
                  ((mask == 4'b0011 && EX_MEMaddr[0]) ||
                   (mask == 4'b1111 && EX_MEMaddr[1:0] != 2'b00));
`else
    // Force natural alignment so the lane shift never pushes enables past lane 3.
    assign off  = (mask == 4'b1111) ? 2'b00 :
                  (mask == 4'b0011) ? {EX_MEMaddr[1], 1'b0} : EX_MEMaddr[1:0];
    assign trap = 1'b0;
`endif
    assign start        = req_any && !illegal && !trap;
    assign tmo          = (cnt == CntW'(TIMEOUT_CYC - 1));
    assign lsu_misalign = mis_q;

    assign rd_done = (state == StReq && bus_gnt && !bus_we && bus_rvalid) ||
                     (state == StRdWait && bus_rvalid);
    assign abort   = tmo && ((state == StReq && !bus_gnt) || (state == StRdWait && !bus_rvalid));

    assign shifted = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_ext = shifted;
        if (size_q == 4'b0001) begin
            ld_ext = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
        end else if (size_q == 4'b0011) begin
            ld_ext = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
        end
    end

    // Stall drops in the completing cycle so the core advances on the same edge the FSM does.
    always_comb begin
        lsu_stall = 1'b0;
        if (!rst) begin
            unique case (state)
                StIdle:   lsu_stall = start;
                StReq:    lsu_stall = bus_gnt ? !(bus_we || bus_rvalid) : !tmo;
                StRdWait: lsu_stall = !bus_rvalid && !tmo;
                default:  lsu_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= '0;
            off_q       <= 2'b00;
            size_q      <= 4'b0000;
            sgn_q       <= 1'b0;
            mis_q       <= 1'b0;
            LSU_rd_vld  <= 1'b0;
            LSU_rd_data <= 32'h0;
            lsu_err     <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'b0000;
            bus_wdata   <= 32'h0;
        end else begin
            LSU_rd_vld <= 1'b0;
            lsu_err    <= 1'b0;
            mis_q      <= 1'b0;
            if (rd_done) begin
                LSU_rd_vld  <= 1'b1;
                LSU_rd_data <= ld_ext;
            end
            if (abort) begin
                lsu_err <= 1'b1;
                if (!bus_we && RD_ZERO_ON_ERR) begin
                    LSU_rd_vld  <= 1'b1;
                    LSU_rd_data <= 32'h0;
                end
            end
            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    if (start) begin
                        bus_req   <= 1'b1;
                        bus_we    <= |EX_MEMwren;
                        bus_addr  <= {EX_MEMaddr[31:2], 2'b00};
                        bus_be    <= mask << off;
                        bus_wdata <= EX_MEMwrdata << {off, 3'b000};
                        off_q     <= off;
                        size_q    <= mask;
                        sgn_q     <= EX_ld_signed;
                        state     <= StReq;
                    end else if (illegal || trap) begin
                        lsu_err <= 1'b1;
                        mis_q   <= trap;
                    end
                end
                StReq: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        state   <= (bus_we || bus_rvalid) ? StIdle : StRdWait;
                    end else if (tmo) begin
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        state   <= StIdle;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StRdWait: begin
                    if (bus_rvalid || tmo) begin
                        cnt   <= '0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
